mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter that shares one `MainMemoryModule` instance between the instruction-fetch path (driven by the program counter) and the load/store data path (driven by the ALU result and control unit). Requesters issue one transaction at a time through a req/gnt/rvalid handshake. The arbiter sequences the memory's read/write strobes and returns read data after a parameterised latency. Data accesses have priority, and a starvation counter guarantees fetch forward progress.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LATENCY`, 1, cycles from the strobe cycle to the cycle `mem_rdata` is valid; legal range 1..15
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which fetch wins; legal range ≥1
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `if_req` in 1: fetch request, read-only
- `if_addr` in AW: fetch address
- `if_gnt` out 1: fetch granted (one-cycle pulse)
- `if_rvalid` out 1: fetch data valid (one-cycle pulse)
- `if_rdata` out DW: fetch data
- `d_req` in 1: data request
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in AW: data address
- `d_wdata` in DW: write data
- `d_gnt` out 1: data granted (one-cycle pulse)
- `d_rvalid` out 1: read data valid, or write acknowledge
- `d_rdata` out DW: data read result
- `mem_addr` out AW: memory address
- `mem_re` out 1: memory read enable
- `mem_we` out 1: memory write enable
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data
- `busy` out 1: transaction in flight (state ≠ IDLE)

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: one cycle; drive the strobe.
  - WAIT: MEM_LATENCY cycles; down-counter `cnt` loaded with MEM_LATENCY−1.
- IDLE arbitration (combinational `gnt` in the same cycle):
  - Only one request: grant it.
  - Both requests: grant data, unless `starve_cnt == STARVE_LIMIT`, in which case grant fetch.
- On grant, the following are captured at the clock edge: owner, address, `we` (forced 0 for fetch), and `wdata`. Next state is ISSUE.
- ISSUE:
  - `mem_re` = !we_q, `mem_we` = we_q, for exactly one cycle.
  - `mem_addr`/`mem_wdata` come from captured registers and are held stable from ISSUE through the end of WAIT.
  - These outputs are 0 in IDLE.
- WAIT:
  - Exit to IDLE when `cnt == 0`.
  - At the exiting edge, `mem_rdata` is registered into the owner's `*_rdata` and the owner's `*_rvalid` is set for one cycle.
- Writes:
  - `d_rvalid` pulses as the acknowledge.
  - `d_rdata` keeps its previous value on writes.
- `if_rdata`/`d_rdata` hold their last value between pulses.
- `starve_cnt`, updated only on IDLE grant cycles:
  - Increments when data is granted while `if_req` = 1 (saturating at STARVE_LIMIT).
  - Clears when fetch is granted.
  - Clears in any IDLE cycle with `if_req` = 0.
- Requester rules:
  - Hold `req`/addr/`we`/`wdata` stable until `gnt`.
  - May drop `req` before `gnt`; no transaction results.
  - Must not expect a grant while `busy`.
- Requests seen while not IDLE are ignored; they are arbitrated on return to IDLE.

## Timing
- Grant in cycle T; strobe in T+1; `mem_rdata` sampled in T+1+MEM_LATENCY; `rvalid` in T+2+MEM_LATENCY.
- The `rvalid` cycle is an IDLE cycle, so a new grant may coincide with it. Back-to-back throughput is one transaction per MEM_LATENCY+2 cycles.
- Reset (`rst` low, asynchronous):
  - State → IDLE, `cnt` = 0, `starve_cnt` = 0.
  - All outputs 0, including `rdata` registers.
- Reset during ISSUE/WAIT abandons the transaction; no `rvalid` follows after release.
- The first grant is possible in the first cycle after `rst` deasserts.
- `gnt` never asserts for both requesters in the same cycle. `rvalid` never asserts for a requester that does not own the transaction.

## Test plan
- Fetch read, MEM_LATENCY=1:
  - Stimulus: `if_req` at T, `if_addr`=0x40, memory returns 0xDEADBEEF.
  - Expect: `if_gnt` at T; `mem_re`=1 with `mem_addr`=0x40 at T+1; `if_rvalid`=1 with `if_rdata`=0xDEADBEEF at T+3.
- Simultaneous requests:
  - Stimulus: `if_req` and `d_req` (read, 0x100) at T.
  - Expect: `d_gnt` at T; `d_rvalid` at T+3; `if_gnt` at T+3; `if_rvalid` at T+6.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: `d_req` and `if_req` held high continuously.
  - Expect: grants D,D,D,D,F,D,D,D,D,F…; `starve_cnt` returns to 0 after each F.
- Data write:
  - Stimulus: `d_we`=1, `d_addr`=0x8, `d_wdata`=0x12345678.
  - Expect: `mem_we`=1 for exactly one cycle with matching addr/data, `mem_re`=0; `d_rvalid` pulse; `d_rdata` unchanged.
- MEM_LATENCY=3:
  - Stimulus: fetch granted at T.
  - Expect: strobe at T+1; `mem_addr` held through T+4; `if_rvalid` at T+5; `busy` high T+1..T+4.
- Reset mid-WAIT:
  - Stimulus: drop `rst` at T+2 of a read, release 2 cycles later.
  - Expect: all outputs 0 immediately on `rst` fall; no `rvalid` afterwards; next request is granted in its first post-reset cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data wins contention unless fetch has lost STARVE_LIMIT arbitrations in a row.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam int             SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [3:0]     CNT_LOAD   = 4'(MEM_LATENCY - 1);

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic [SW-1:0] starve_cnt;
   logic          own_d;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          starved;

   assign starved = (starve_cnt == STARVE_MAX);

   // Grants are gated by reset so every output reads 0 while rst is low.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (state == IDLE && rst) begin
         if_gnt = if_req && (!d_req || starved);
         d_gnt  = d_req && !if_gnt;
      end
   end

   assign busy      = (state != IDLE);
   assign mem_re    = (state == ISSUE) && !we_q;
   assign mem_we    = (state == ISSUE) && we_q;
   assign mem_addr  = busy ? addr_q  : '0;
   assign mem_wdata = busy ? wdata_q : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         starve_cnt <= '0;
         own_d      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         d_rvalid   <= 1'b0;
         d_rdata    <= '0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         case (state)
            IDLE: begin
               if (!if_req || if_gnt) begin
                  starve_cnt <= '0;
               end else if (d_gnt && !starved) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
               if (if_gnt || d_gnt) begin
                  own_d   <= d_gnt;
                  we_q    <= d_gnt && d_we;
                  addr_q  <= d_gnt ? d_addr : if_addr;
                  // Fetch carries no write data; drive zeros on mem_wdata.
                  wdata_q <= d_gnt ? d_wdata : '0;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= CNT_LOAD;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  if (own_d) begin
                     d_rvalid <= 1'b1;
                     if (!we_q) d_rdata <= mem_rdata;
                  end else begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 / 3) checked every cycle
// against a timeline model built from grant cycle numbers.
module tb_mem_port_arbiter;

   localparam int L0 = 1;
   localparam int L1 = 3;
   localparam int S0 = 4;
   localparam int S1 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst, if_req, d_req, d_we;
   logic [1:0][31:0]  if_addr, d_addr, d_wdata, mem_rdata;
   logic [1:0]        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_re, mem_we, busy;
   logic [1:0][31:0]  if_rdata, d_rdata, mem_addr, mem_wdata;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(L0), .STARVE_LIMIT(S0)) dut0 (
      .clk(clk), .rst(rst[0]),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
      .mem_addr(mem_addr[0]), .mem_re(mem_re[0]), .mem_we(mem_we[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]));

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(L1), .STARVE_LIMIT(S1)) dut1 (
      .clk(clk), .rst(rst[1]),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
      .mem_addr(mem_addr[1]), .mem_re(mem_re[1]), .mem_we(mem_we[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL lane%0d %s: got %h want %h at %0t", l, name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input int l, input logic act, input logic exp);
      chk(name, l, {31'b0, act}, {31'b0, exp});
   endtask

   function automatic int lat(input int l);
      return (l == 0) ? L0 : L1;
   endfunction

   function automatic int stv(input int l);
      return (l == 0) ? S0 : S1;
   endfunction

   // Initial memory image; word 0x40 holds the fetch test pattern.
   function automatic logic [31:0] mem_init(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
   endfunction

   // ---------------- behavioural model + single compare process ----------------
   logic [31:0] ref_mem [logic [32:0]];
   longint      mcyc = 0;
   bit          m_have [2] = '{1'b0, 1'b0};
   longint      m_g [2];
   bit          m_own_d [2];
   bit          m_we [2];
   logic [31:0] m_addr [2], m_wd [2], m_dat [2], m_ifr [2], m_dr [2];
   int          m_starve [2];

   task automatic model_lane(input int l);
      int          lt;
      logic [32:0] key;
      logic        idle, rv, stb;
      logic        e_ig, e_dg, e_irv, e_drv, e_re, e_we, e_busy;
      logic [31:0] e_addr, e_wd;
      lt = lat(l);
      idle = 1'b0; rv = 1'b0; stb = 1'b0;
      e_ig = 1'b0; e_dg = 1'b0; e_irv = 1'b0; e_drv = 1'b0;
      e_re = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_addr = '0; e_wd = '0;
      if (!rst[l]) begin
         m_have[l] = 1'b0;
         m_starve[l] = 0;
         m_ifr[l] = '0;
         m_dr[l] = '0;
      end else begin
         idle   = !m_have[l] || (mcyc >= m_g[l] + 2 + lt);
         rv     = m_have[l] && (mcyc == m_g[l] + 2 + lt);
         e_irv  = rv && !m_own_d[l];
         e_drv  = rv && m_own_d[l];
         if (e_irv) m_ifr[l] = m_dat[l];
         if (e_drv && !m_we[l]) m_dr[l] = m_dat[l];
         e_busy = m_have[l] && (mcyc >= m_g[l] + 1) && (mcyc <= m_g[l] + 1 + lt);
         stb    = m_have[l] && (mcyc == m_g[l] + 1);
         e_re   = stb && !m_we[l];
         e_we   = stb && m_we[l];
         e_addr = e_busy ? m_addr[l] : '0;
         e_wd   = e_busy ? m_wd[l] : '0;
         if (idle) begin
            e_ig = if_req[l] && (!d_req[l] || m_starve[l] == stv(l));
            e_dg = d_req[l] && !e_ig;
         end
      end
      chk1("if_gnt", l, if_gnt[l], e_ig);
      chk1("d_gnt", l, d_gnt[l], e_dg);
      chk1("if_rvalid", l, if_rvalid[l], e_irv);
      chk1("d_rvalid", l, d_rvalid[l], e_drv);
      chk("if_rdata", l, if_rdata[l], m_ifr[l]);
      chk("d_rdata", l, d_rdata[l], m_dr[l]);
      chk1("mem_re", l, mem_re[l], e_re);
      chk1("mem_we", l, mem_we[l], e_we);
      chk("mem_addr", l, mem_addr[l], e_addr);
      chk("mem_wdata", l, mem_wdata[l], e_wd);
      chk1("busy", l, busy[l], e_busy);
      if (rst[l] && idle) begin
         if (!if_req[l] || e_ig) m_starve[l] = 0;
         else if (e_dg && m_starve[l] < stv(l)) m_starve[l] = m_starve[l] + 1;
         if (e_ig || e_dg) begin
            m_have[l]  = 1'b1;
            m_g[l]     = mcyc;
            m_own_d[l] = e_dg;
            m_addr[l]  = e_dg ? d_addr[l] : if_addr[l];
            m_we[l]    = e_dg && d_we[l];
            m_wd[l]    = e_dg ? d_wdata[l] : '0;
            key = {l[0], m_addr[l]};
            if (m_we[l]) ref_mem[key] = m_wd[l];
            m_dat[l] = ref_mem.exists(key) ? ref_mem[key] : mem_init(m_addr[l]);
         end
      end
   endtask

   always @(negedge clk) begin
      model_lane(0);
      model_lane(1);
      mcyc++;
   end

   // ---------------- memory device and stimulus ----------------
   logic [31:0] dev_mem [logic [32:0]];
   longint      ccyc = 0;
   longint      rd_due [2] = '{-1, -1};
   logic [31:0] rd_data [2];

   task automatic dev_step();
      logic [32:0] key;
      ccyc++;
      for (int l = 0; l < 2; l++) begin
         key = {l[0], mem_addr[l]};
         if (!rst[l]) begin
            rd_due[l] = -1;
         end else begin
            if (mem_re[l]) begin
               rd_due[l]  = ccyc + lat(l);
               rd_data[l] = dev_mem.exists(key) ? dev_mem[key] : mem_init(mem_addr[l]);
            end
            if (mem_we[l]) dev_mem[key] = mem_wdata[l];
         end
         mem_rdata[l] = (ccyc == rd_due[l]) ? rd_data[l] : $urandom;
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      dev_step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic [1:0] gi, gd;
      int         n, budget, rvc;
      int         hold [2];
      rst = 2'b00; if_req = 2'b00; d_req = 2'b00; d_we = 2'b00;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      hold = '{0, 0};

      // Requests during reset must not be granted.
      if_req[0] = 1'b1; d_req[0] = 1'b1;
      @(negedge clk);
      chk1("rst if_gnt", 0, if_gnt[0], 1'b0);
      chk1("rst d_gnt", 0, d_gnt[0], 1'b0);
      chk1("rst busy", 0, busy[0], 1'b0);
      chk("rst if_rdata", 0, if_rdata[0], 32'h0);
      if_req[0] = 1'b0; d_req[0] = 1'b0;
      next();
      rst = 2'b11;
      next(); next();

      // Fetch read of 0x40, latency 1.
      if_addr[0] = 32'h40; if_req[0] = 1'b1;
      @(negedge clk); chk1("fetch gnt T", 0, if_gnt[0], 1'b1);
      next(); if_req[0] = 1'b0;
      @(negedge clk);
      chk1("fetch mem_re T+1", 0, mem_re[0], 1'b1);
      chk("fetch mem_addr T+1", 0, mem_addr[0], 32'h40);
      next(); next();
      @(negedge clk);
      chk1("fetch rvalid T+3", 0, if_rvalid[0], 1'b1);
      chk("fetch rdata T+3", 0, if_rdata[0], 32'hDEADBEEF);
      next();

      // Simultaneous requests: data first, fetch follows on the rvalid cycle.
      if_addr[0] = 32'h200; d_addr[0] = 32'h100; d_we[0] = 1'b0;
      if_req[0] = 1'b1; d_req[0] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk1("sim d_gnt", 0, d_gnt[0], k == 0);
         chk1("sim if_gnt", 0, if_gnt[0], k == 3);
         chk1("sim d_rvalid", 0, d_rvalid[0], k == 3);
         chk1("sim if_rvalid", 0, if_rvalid[0], k == 6);
         chk1("sim busy", 0, busy[0], k == 1 || k == 2 || k == 4 || k == 5);
         next();
         if (k == 0) d_req[0] = 1'b0;
         if (k == 3) if_req[0] = 1'b0;
      end
      chk("sim d_rdata", 0, d_rdata[0], mem_init(32'h100));
      chk("sim if_rdata", 0, if_rdata[0], mem_init(32'h200));

      // Starvation: both held, expect D D D D F D D D D F.
      if_req[0] = 1'b1; d_req[0] = 1'b1;
      n = 0; budget = 200;
      while (n < 10 && budget > 0) begin
         @(negedge clk);
         if (if_gnt[0] || d_gnt[0]) begin
            chk1("starve grant is fetch", 0, if_gnt[0], (n % 5) == 4);
            n++;
         end
         next();
         budget--;
      end
      chk("starve grant count", 0, n, 10);
      if_req[0] = 1'b0; d_req[0] = 1'b0;
      for (int k = 0; k < 6; k++) next();

      // Data write: one-cycle mem_we, ack pulse, d_rdata untouched.
      d_we[0] = 1'b1; d_addr[0] = 32'h8; d_wdata[0] = 32'h12345678; d_req[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk1("wr d_gnt", 0, d_gnt[0], k == 0);
         chk1("wr mem_we", 0, mem_we[0], k == 1);
         chk1("wr mem_re", 0, mem_re[0], 1'b0);
         chk("wr mem_addr", 0, mem_addr[0], (k == 1 || k == 2) ? 32'h8 : 32'h0);
         chk("wr mem_wdata", 0, mem_wdata[0], (k == 1 || k == 2) ? 32'h12345678 : 32'h0);
         chk1("wr d_rvalid", 0, d_rvalid[0], k == 3);
         chk("wr d_rdata", 0, d_rdata[0], mem_init(32'h100));
         next();
         if (k == 0) d_req[0] = 1'b0;
      end
      d_we[0] = 1'b0;

      // Reset in the WAIT cycle abandons the read.
      if_addr[0] = 32'h44; if_req[0] = 1'b1;
      @(negedge clk); chk1("rstw gnt", 0, if_gnt[0], 1'b1);
      next(); if_req[0] = 1'b0;
      next();
      rst[0] = 1'b0;
      #1;
      chk1("rstw busy", 0, busy[0], 1'b0);
      chk("rstw mem_addr", 0, mem_addr[0], 32'h0);
      chk("rstw if_rdata", 0, if_rdata[0], 32'h0);
      chk("rstw d_rdata", 0, d_rdata[0], 32'h0);
      next(); next();
      rst[0] = 1'b1; if_addr[0] = 32'h48; if_req[0] = 1'b1;
      @(negedge clk); chk1("post-reset gnt", 0, if_gnt[0], 1'b1);
      rvc = 0;
      for (int k = 0; k < 8; k++) begin
         next();
         if (k == 0) if_req[0] = 1'b0;
         @(negedge clk);
         rvc += int'(if_rvalid[0]);
      end
      chk("post-reset rvalid count", 0, rvc, 1);
      chk("post-reset if_rdata", 0, if_rdata[0], mem_init(32'h48));
      next();

      // Latency 3 instance: fetch timeline.
      if_addr[1] = 32'h80; if_req[1] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk1("l3 if_gnt", 1, if_gnt[1], k == 0);
         chk1("l3 mem_re", 1, mem_re[1], k == 1);
         chk("l3 mem_addr", 1, mem_addr[1], (k >= 1 && k <= 4) ? 32'h80 : 32'h0);
         chk1("l3 busy", 1, busy[1], k >= 1 && k <= 4);
         chk1("l3 if_rvalid", 1, if_rvalid[1], k == 5);
         next();
         if (k == 0) if_req[1] = 1'b0;
      end
      chk("l3 if_rdata", 1, if_rdata[1], mem_init(32'h80));

      // Random traffic on both instances, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         gi = if_gnt; gd = d_gnt;
         next();
         for (int l = 0; l < 2; l++) begin
            if (hold[l] > 0) begin
               hold[l]--;
               if (hold[l] == 0) rst[l] = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
               rst[l] = 1'b0;
               hold[l] = int'($urandom_range(1, 3));
            end
            if (if_req[l] && !gi[l]) begin
               if ($urandom_range(0, 15) == 0) if_req[l] = 1'b0;
            end else begin
               if_req[l]  = ($urandom_range(0, 3) != 0);
               if_addr[l] = 32'($urandom_range(0, 15)) << 2;
            end
            if (d_req[l] && !gd[l]) begin
               if ($urandom_range(0, 15) == 0) d_req[l] = 1'b0;
            end else begin
               d_req[l]   = ($urandom_range(0, 3) != 0);
               d_we[l]    = ($urandom_range(0, 2) == 0);
               d_addr[l]  = 32'($urandom_range(0, 15)) << 2;
               d_wdata[l] = $urandom;
            end
         end
      end
      if_req = 2'b00; d_req = 2'b00; rst = 2'b11;
      for (int k = 0; k < 10; k++) next();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
